cuckatoo_edge_gen: RTL

Sequencer upstream of the cuckatoo graph stage. It drives the siphash register interface to hash nonces 2i and 2i+1 for every edge index i. It masks both results to EDGE_BITS and emits (edge_idx, u, v) on a valid/ready stream consumed by the node/edge RAM writer. It replaces the hand-written single-hash sequence in the top level with a full edge sweep.

---
 rtl/cuckatoo_pkg.sv | 31 +++
 rtl/siphash_bus_master.sv | 50 +++++
 rtl/cuckatoo_edge_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cuckatoo_pkg.sv
// Shared constants for the cuckatoo edge generator: siphash register map,
// CTRL opcodes, and the sequencer state encoding.
package cuckatoo_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_KEY0   = 8'h10;
    localparam logic [7:0] ADDR_KEY1   = 8'h11;
    localparam logic [7:0] ADDR_KEY2   = 8'h12;
    localparam logic [7:0] ADDR_KEY3   = 8'h13;
    localparam logic [7:0] ADDR_NONCE  = 8'h18;
    localparam logic [7:0] ADDR_WORD0  = 8'h20;

    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_INIT     = 3'd1,
        OP_COMPRESS = 3'd2,
        OP_FINALIZE = 3'd4
    } ctrl_op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WKEY, S_WCTRL, S_POLL, S_WNONCE, S_RWORD, S_EMIT, S_FIN
    } state_t;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [63:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/siphash_bus_master.sv
// Two-cycle siphash register access: cycle A drives the strobe, cycle B
// returns ack and read data. Holding i_req through B then asserting it again
// in the following cycle gives back-to-back ops with no idle gap.
module siphash_bus_master
    import cuckatoo_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  bus_req_t    i_pkt,
    output logic        o_ack,
    output logic [63:0] o_rdata,
    output logic        o_sip_cs,
    output logic        o_sip_we,
    output logic [7:0]  o_sip_addr,
    output logic [63:0] o_sip_write_data,
    input  logic [63:0] i_sip_read_data
);

    logic        r_phase_b;
    logic [7:0]  r_addr;
    logic [63:0] r_wdata;
    logic        w_cyc_a;
    logic        w_wr_a;

    assign w_cyc_a = i_req & ~r_phase_b;
    assign w_wr_a  = w_cyc_a & i_pkt.we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase_b <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_phase_b <= w_cyc_a;
            if (w_cyc_a) r_addr  <= i_pkt.addr;
            if (w_wr_a)  r_wdata <= i_pkt.wdata;
        end
    end

    // Strobes come straight from the caller's state registers, so an async
    // reset of the caller drops them in the same instant.
    assign o_sip_cs         = w_cyc_a;
    assign o_sip_we         = w_wr_a;
    assign o_sip_addr       = w_cyc_a ? i_pkt.addr  : r_addr;
    assign o_sip_write_data = w_wr_a  ? i_pkt.wdata : r_wdata;
    assign o_ack            = r_phase_b;
    assign o_rdata          = i_sip_read_data;

endmodule

// File: rtl/cuckatoo_edge_gen.sv
// Edge sweep sequencer: hashes nonces 2i and 2i+1 through the siphash
// register interface and streams (i, u, v) to the graph RAM writer.
module cuckatoo_edge_gen
    import cuckatoo_pkg::*;
#(
    parameter int EDGE_BITS  = 10,
    parameter int POLL_LIMIT = 64
) (
    input  logic                 CLOCK,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [255:0]         key,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 sip_cs,
    output logic                 sip_we,
    output logic [7:0]           sip_addr,
    output logic [63:0]          sip_write_data,
    input  logic [63:0]          sip_read_data,
    output logic                 edge_valid,
    input  logic                 edge_ready,
    output logic [EDGE_BITS-1:0] edge_idx,
    output logic [EDGE_BITS-1:0] edge_u,
    output logic [EDGE_BITS-1:0] edge_v
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    state_t               r_state, w_next;
    logic [255:0]         r_key;
    logic [1:0]           r_kidx;
    ctrl_op_t             r_op;
    logic [PW-1:0]        r_poll;
    logic [EDGE_BITS-1:0] r_idx, r_u, r_v;
    logic                 r_half;
    logic                 r_busy, r_done, r_error;

    logic                 w_req, w_ack;
    bus_req_t             w_pkt;
    logic [63:0]          w_rdata;
    logic                 w_ready, w_poll_out, w_last;
    logic                 w_unused_rdata;

    assign w_ready        = w_rdata[0];
    assign w_poll_out     = (r_poll == PW'(POLL_LIMIT - 1));
    assign w_last         = &r_idx;
    assign w_unused_rdata = ^w_rdata[63:EDGE_BITS];

    siphash_bus_master u_bus (
        .i_clk            (CLOCK),
        .i_rst_n          (reset_n),
        .i_req            (w_req),
        .i_pkt            (w_pkt),
        .o_ack            (w_ack),
        .o_rdata          (w_rdata),
        .o_sip_cs         (sip_cs),
        .o_sip_we         (sip_we),
        .o_sip_addr       (sip_addr),
        .o_sip_write_data (sip_write_data),
        .i_sip_read_data  (sip_read_data)
    );

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_pkt  = '0;
        case (r_state)
            S_IDLE: if (start) w_next = S_WKEY;
            S_WKEY: begin
                w_req = 1'b1;
                w_pkt = '{we: 1'b1, addr: ADDR_KEY0 + {6'd0, r_kidx},
                          wdata: r_key[{r_kidx, 6'd0} +: 64]};
                if (w_ack && r_kidx == 2'd3) w_next = S_WCTRL;
            end
            S_WCTRL: begin
                w_req = 1'b1;
                w_pkt = '{we: 1'b1, addr: ADDR_CTRL, wdata: 64'(r_op)};
                if (w_ack) w_next = S_POLL;
            end
            S_POLL: begin
                w_req = 1'b1;
                w_pkt = '{we: 1'b0, addr: ADDR_STATUS, wdata: 64'd0};
                if (w_ack) begin
                    if (w_ready) begin
                        if (r_op == OP_INIT)          w_next = S_WNONCE;
                        else if (r_op == OP_COMPRESS) w_next = S_WCTRL;
                        else                          w_next = S_RWORD;
                    end else if (w_poll_out) begin
                        w_next = S_FIN;
                    end
                end
            end
            S_WNONCE: begin
                w_req = 1'b1;
                w_pkt = '{we: 1'b1, addr: ADDR_NONCE, wdata: 64'({r_idx, r_half})};
                if (w_ack) w_next = S_WCTRL;
            end
            S_RWORD: begin
                w_req = 1'b1;
                w_pkt = '{we: 1'b0, addr: ADDR_WORD0, wdata: 64'd0};
                if (w_ack) w_next = r_half ? S_EMIT : S_WCTRL;
            end
            S_EMIT: if (edge_ready) w_next = w_last ? S_FIN : S_WCTRL;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            r_key   <= '0;
            r_kidx  <= '0;
            r_op    <= OP_INIT;
            r_poll  <= '0;
            r_idx   <= '0;
            r_u     <= '0;
            r_v     <= '0;
            r_half  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_key   <= key;
                    r_kidx  <= '0;
                    r_op    <= OP_INIT;
                    r_idx   <= '0;
                    r_half  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
                S_WKEY:  if (w_ack) r_kidx <= r_kidx + 2'd1;
                S_WCTRL: if (w_ack) r_poll <= '0;
                S_POLL: if (w_ack) begin
                    // Advance the opcode here so the next WCTRL writes the right step.
                    if (w_ready) begin
                        if (r_op == OP_INIT)          r_op <= OP_COMPRESS;
                        else if (r_op == OP_COMPRESS) r_op <= OP_FINALIZE;
                    end else begin
                        r_poll <= r_poll + PW'(1);
                        if (w_poll_out) r_error <= 1'b1;
                    end
                end
                S_RWORD: if (w_ack) begin
                    if (!r_half) begin
                        r_u    <= w_rdata[EDGE_BITS-1:0];
                        r_half <= 1'b1;
                        r_op   <= OP_INIT;
                    end else begin
                        r_v    <= w_rdata[EDGE_BITS-1:0];
                    end
                end
                S_EMIT: if (edge_ready && !w_last) begin
                    r_idx  <= r_idx + EDGE_BITS'(1);
                    r_half <= 1'b0;
                    r_op   <= OP_INIT;
                end
                S_FIN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign edge_valid = (r_state == S_EMIT);
    assign edge_idx   = r_idx;
    assign edge_u     = r_u;
    assign edge_v     = r_v;

endmodule
